onehot_serial_encoder: RTL and testbench
========================================

Name: onehot_serial_encoder

Overview:
- 8-to-3 encoder: the opposite direction of the team's 3-to-8 one-hot decoder.
- Accepts one 8-bit request word through a valid/ready handshake.
- Serialises every set bit of that word into a stream of 3-bit binary codes, one code per output handshake.
- Sits between a request/flag source and any consumer that expects a binary index, for example a decoder driving select lines.

Parameters:
- N, default 8: request word width. Only 8 is supported and verified.
- CODE_W, default 3: output code width. Must equal clog2(N).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- IN_VALID  in  1  request word present on IN_BITS
- IN_READY  out  1  block can accept a word
- IN_BITS  in  8  request word; bit i set means code i is to be emitted
- OUT_VALID  out  1  OUT_CODE/OUT_LAST valid
- OUT_READY  in  1  consumer accepts the code
- OUT_CODE  out  3  binary index of the current set bit
- OUT_LAST  out  1  current code is the final one for this word
- ERR_EMPTY  out  1  one-cycle pulse: an all-zero word was accepted

Behaviour:
- One clock, CLK. RST_N is asynchronous and active-low. All state is cleared immediately on RST_N=0, regardless of CLK.
- Reset values: state=IDLE, pending=8'h00, IN_READY=1, OUT_VALID=0, OUT_CODE=3'd0, OUT_LAST=0, ERR_EMPTY=0.
- States: IDLE, EMIT.
- IDLE:
  - IN_READY=1, OUT_VALID=0.
  - On IN_VALID&IN_READY with IN_BITS!=0: pending<=IN_BITS, go to EMIT.
  - On IN_VALID&IN_READY with IN_BITS==0: ERR_EMPTY=1 in the next cycle only, stay in IDLE, no code is emitted.
- EMIT:
  - IN_READY=0, OUT_VALID=1.
  - OUT_CODE = index of the lowest set bit of pending.
  - OUT_LAST = 1 when pending has exactly one bit set.
  - OUT_CODE and OUT_LAST are decoded from the pending register only, never from IN_BITS.
  - On OUT_VALID&OUT_READY: clear that bit in pending. If OUT_LAST, go to IDLE; otherwise stay in EMIT.
- Latency: word accepted at edge k gives the first code valid in the cycle after edge k.
- Throughput:
  - One code per cycle while OUT_READY=1.
  - The word occupies popcount(IN_BITS) cycles, plus 1 IDLE cycle before the next word can be accepted.
- Backpressure: while OUT_VALID=1 and OUT_READY=0, OUT_CODE and OUT_LAST hold stable and pending is unchanged.
- Input bits: IN_BITS is sampled only on the accepting edge. Changes while in EMIT are ignored.
- OUT_VALID never drops without a completed handshake, except on reset.
- Reset mid-word: OUT_VALID falls asynchronously and pending codes are discarded. After release the block is in IDLE with IN_READY=1.
- 8'hFF produces 8 codes, 0 through 7. A single-bit word produces exactly one code, with OUT_LAST=1.

Optional Feature:
- Macro: ONEHOT_ENC_MSB_FIRST_EN.
- Defined: scan order is highest set bit first. OUT_CODE = index of the MSB of pending. OUT_LAST rule is unchanged.
- Undefined (default): scan order is lowest set bit first, as described above.
- Handshake, latency and reset behaviour are identical in both builds.

Decomposition:
- Package onehot_enc_pkg holds:
  - localparams N=8, CODE_W=3
  - state typedef enum {IDLE, EMIT}
- One combinational sub-module, ffs8: 8-bit input gives a 3-bit index and a single-bit flag ("exactly one bit set"). Direction is selected by ONEHOT_ENC_MSB_FIRST_EN.
- The FSM and pending register stay in onehot_serial_encoder.

Test Plan:
- Reset: assert RST_N=0 with IN_VALID=1 -> IN_READY=1, OUT_VALID=0, OUT_CODE=0, OUT_LAST=0, ERR_EMPTY=0, checked without any CLK edge.
- IN_BITS=8'b1010_0100 with OUT_READY=1 -> codes 2,5,7 on consecutive cycles, OUT_LAST only with code 7, IN_READY=1 the following cycle.
  - With ONEHOT_ENC_MSB_FIRST_EN defined -> codes 7,5,2.
- IN_BITS=8'h01 with OUT_READY=0 for 3 cycles, then 1 -> OUT_CODE=0 and OUT_LAST=1 held stable for 4 cycles, a single transfer, then IDLE.
- IN_BITS=8'h00 accepted -> ERR_EMPTY high exactly one cycle, OUT_VALID stays 0, IN_READY stays 1.
- IN_BITS=8'hFF, OUT_READY=1 -> codes 0..7 in 8 consecutive cycles. A second word offered meanwhile is not accepted until IDLE.
- IN_BITS=8'hF0, drop RST_N after 2 codes (4,5) -> OUT_VALID=0 immediately. After release, new word 8'h02 yields only code 1; no stale 6 or 7 appears.

Source files
------------

// File: rtl/onehot_enc_pkg.sv
// Shared constants and state type for the one-hot serial encoder.
package onehot_enc_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/ffs8.sv
// Find-set-bit helper: index of the next bit to emit plus an "exactly one bit set" flag.
// Scan direction: lowest set bit first by default, highest set bit first when
// ONEHOT_ENC_MSB_FIRST_EN is defined.
module ffs8
  import onehot_enc_pkg::*;
(
  input  logic [N-1:0]      bits,
  output logic [CODE_W-1:0] idx,
  output logic              single
);

  // Priority scan; the last match written wins, so the loop runs towards the preferred end.
  always_comb begin
    idx = '0;
`ifdef ONEHOT_ENC_MSB_FIRST_EN
    for (int i = 0; i < int'(N); i++) begin
      if (bits[i]) idx = CODE_W'(i);
    end
`else
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (bits[i]) idx = CODE_W'(i);
    end
`endif
  end

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
  always_comb begin
    single = (bits != '0) && ((bits & (bits - N'(1))) == '0);
  end

endmodule

// File: rtl/onehot_serial_encoder.sv
// Accepts one 8-bit request word and emits the index of each set bit as a 3-bit code,
// one code per output handshake. Scan order is selected by ONEHOT_ENC_MSB_FIRST_EN
// (undefined: lowest bit first; defined: highest bit first).
module onehot_serial_encoder #(
  parameter int unsigned N      = 8,
  parameter int unsigned CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              err_empty
);

  import onehot_enc_pkg::*;

  state_e              state_q, state_d;
  logic [N-1:0]        pending_q, pending_d;
  logic                err_q, err_d;
  logic [CODE_W-1:0]   next_code;
  logic                next_single;
  logic                in_fire;
  logic                out_fire;

  // Codes are decoded from the pending register only, never from in_bits.
  ffs8 u_ffs8 (
    .bits   (pending_q),
    .idx    (next_code),
    .single (next_single)
  );

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE on a non-empty word, return after the last code transfers.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_fire && (in_bits != '0)) state_d = EMIT;
      EMIT: if (out_fire && next_single)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and pending; pending is zero in IDLE so code/last read as 0.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == EMIT);
    out_code  = next_code;
    out_last  = next_single;
    err_empty = err_q;
  end

  // Pending word and empty-word error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Load on accept; on each transfer clear exactly the bit just emitted.
  always_comb begin
    pending_d = pending_q;
    if (in_fire) begin
      pending_d = in_bits;
    end else if (out_fire) begin
      pending_d = pending_q & ~(N'(1) << next_code);
    end
    err_d = in_fire && (in_bits == '0);
  end

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Self-checking bench for onehot_serial_encoder: directed cases plus random words,
// compared against a list-of-indices reference model.
module tb_onehot_serial_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_bits;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;
  logic       err_empty;
  logic       clk_en;

  int errors = 0;
  int checks = 0;

  onehot_serial_encoder #(
    .N      (8),
    .CODE_W (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .err_empty (err_empty)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the codes a word must produce, in scan order.
  function automatic void model(input logic [7:0] w, output int q[$]);
    q = {};
    for (int i = 0; i < 8; i++) begin
      if (w[i]) begin
`ifdef ONEHOT_ENC_MSB_FIRST_EN
        q.push_front(i);
`else
        q.push_back(i);
`endif
      end
    end
  endfunction

  // Offer a word at a negedge and follow it to completion.
  // mode 0: out_ready always 1; 1: random; 2: low for 3 cycles then high.
  task automatic run_word(input string tag, input logic [7:0] w, input int mode);
    int q[$];
    int cyc;
    int emitted;
    logic rdy;
    model(w, q);
    chk({tag, "_in_ready_pre"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_bits  = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_bits  = 8'($urandom);
    if (w == 8'h00) begin
      chk({tag, "_err_pulse"}, int'(err_empty), 1);
      chk({tag, "_err_no_valid"}, int'(out_valid), 0);
      chk({tag, "_err_ready"}, int'(in_ready), 1);
      @(negedge clk);
      chk({tag, "_err_cleared"}, int'(err_empty), 0);
      chk({tag, "_err_no_valid2"}, int'(out_valid), 0);
      return;
    end
    chk({tag, "_no_err"}, int'(err_empty), 0);
    cyc     = 0;
    emitted = 0;
    while (q.size() > 0) begin
      if (cyc > 200) begin
        chk({tag, "_timeout"}, 1, 0);
        out_ready = 1'b0;
        return;
      end
      chk({tag, "_valid"}, int'(out_valid), 1);
      chk({tag, "_busy"}, int'(in_ready), 0);
      chk({tag, "_code"}, int'(out_code), q[0]);
      chk({tag, "_last"}, int'(out_last), int'(q.size() == 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom);
        default: rdy = (cyc >= 3);
      endcase
      out_ready = rdy;
      // A competing word must not be taken while emitting.
      in_valid  = 1'($urandom);
      in_bits   = 8'($urandom);
      @(negedge clk);
      if (rdy) begin
        void'(q.pop_front());
        emitted++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (mode == 0) chk({tag, "_cycles"}, cyc, $countones(w));
    chk({tag, "_emitted"}, emitted, $countones(w));
    chk({tag, "_idle_valid"}, int'(out_valid), 0);
    chk({tag, "_idle_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int q[$];
    clk_en    = 1'b0;
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_bits   = 8'hA5;
    out_ready = 1'b1;

    // Reset without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_code", int'(out_code), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_err_empty", int'(err_empty), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clk_en    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_word("a4", 8'b1010_0100, 0);
    run_word("single_bp", 8'h01, 2);
    run_word("empty", 8'h00, 0);
    @(negedge clk);
    run_word("ff", 8'hFF, 0);
    run_word("single_msb", 8'h80, 0);

    // Reset mid-word: two codes, then drop reset and check no stale codes survive.
    model(8'hF0, q);
    in_valid  = 1'b1;
    in_bits   = 8'hF0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("f0_valid", int'(out_valid), 1);
      chk("f0_code", int'(out_code), q[0]);
      void'(q.pop_front());
      @(negedge clk);
    end
    chk("f0_valid_before_rst", int'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("f0_rst_valid", int'(out_valid), 0);
    chk("f0_rst_ready", int'(in_ready), 1);
    chk("f0_rst_code", int'(out_code), 0);
    chk("f0_rst_last", int'(out_last), 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_word("post_rst", 8'h02, 0);

    // Random words with random backpressure.
    for (int r = 0; r < 40; r++) begin
      logic [7:0] w;
      w = 8'($urandom);
      if (r % 10 == 0) w = 8'h00;
      run_word("rand", w, 1);
      if (w == 8'h00) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
